// File: rtl/eq_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eq_reg_pkg
// Description : Shared constants for the equalizer I2C register controller:
//               FSM state encodings, data/pointer widths and default values
//               for the gain registers and the out-of-range read value.
// Revision    : 1.0 - initial release
// ============================================================================
package eq_reg_pkg;

    localparam int GAIN_W  = 8;
    localparam int PTR_W   = 8;
    localparam int STATE_W = 2;

    localparam logic [GAIN_W-1:0] DEF_RESET_GAIN = 8'h80;
    localparam logic [GAIN_W-1:0] DEF_OOR_DATA   = 8'hFF;

    // Transaction FSM states
    localparam logic [STATE_W-1:0] c_st_idle = 2'd0;  // no transaction
    localparam logic [STATE_W-1:0] c_st_ptr  = 2'd1;  // waiting for pointer byte
    localparam logic [STATE_W-1:0] c_st_wr   = 2'd2;  // receiving data bytes
    localparam logic [STATE_W-1:0] c_st_rd   = 2'd3;  // streaming bytes to master

endpackage : eq_reg_pkg
`default_nettype wire

// File: rtl/eq_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : eq_reg_bank
// Description : Gain register storage. Holds the active bank (presented as a
//               flat bus to the filter datapath) and, when EQ_SHADOW_COMMIT_EN
//               is defined, a shadow bank that collects writes and is copied
//               to the active bank on commit. Also provides the registered
//               read mux feeding the I2C slave transmit byte.
// Ports       : clk, reset (async, active-low)
//               i_wr_en/i_wr_addr/i_wr_data : in-range register write
//               i_commit                    : copy shadow -> active
//               i_rd_addr / o_rd_data       : registered read path
//               o_gains_flat                : active gains, reg i at [8i+7:8i]
//               o_cfg_update                : 1-cycle pulse on gain change
// Config      : EQ_SHADOW_COMMIT_EN selects the shadow/commit bank scheme.
// Revision    : 1.0 - initial release
// ============================================================================
module eq_reg_bank
    import eq_reg_pkg::*;
#(
    parameter int                NUM_REGS   = 10,
    parameter logic [GAIN_W-1:0] RESET_GAIN = DEF_RESET_GAIN,
    parameter logic [GAIN_W-1:0] OOR_DATA   = DEF_OOR_DATA
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr_en,
    input  logic [PTR_W-1:0]           i_wr_addr,
    input  logic [GAIN_W-1:0]          i_wr_data,
    input  logic                       i_commit,
    input  logic [PTR_W-1:0]           i_rd_addr,
    output logic [GAIN_W-1:0]          o_rd_data,
    output logic [NUM_REGS*GAIN_W-1:0] o_gains_flat,
    output logic                       o_cfg_update
);

    // Contents seen by the read path (shadow bank in commit mode)
    logic [GAIN_W-1:0] w_rd_bank [NUM_REGS];
    logic [GAIN_W-1:0] w_rd_next;
    logic [GAIN_W-1:0] r_rd_data;
    logic              r_cfg_update;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [PTR_W-1:0] c_addr = PTR_W'(gi);

            logic              w_hit;
            logic [GAIN_W-1:0] r_active;

            assign w_hit = i_wr_en && (i_wr_addr == c_addr);

`ifdef EQ_SHADOW_COMMIT_EN
            logic [GAIN_W-1:0] r_shadow;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_shadow <= RESET_GAIN;
                    r_active <= RESET_GAIN;
                end else begin
                    if (w_hit) begin
                        r_shadow <= i_wr_data;
                    end
                    // A write landing in the commit cycle must be part of
                    // the committed image, so bypass the shadow flop.
                    if (i_commit) begin
                        r_active <= w_hit ? i_wr_data : r_shadow;
                    end
                end
            end

            assign w_rd_bank[gi] = r_shadow;
`else
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_active <= RESET_GAIN;
                end else if (w_hit) begin
                    r_active <= i_wr_data;
                end
            end

            assign w_rd_bank[gi] = r_active;
`endif
            assign o_gains_flat[gi*GAIN_W +: GAIN_W] = r_active;
        end
    endgenerate

`ifndef EQ_SHADOW_COMMIT_EN
    // Single-bank build updates gains on every write; commit has no role.
    logic w_unused_commit;
    assign w_unused_commit = i_commit;
`endif

    // Read mux: a pointer past the last register returns OOR_DATA.
    always_comb begin
        w_rd_next = OOR_DATA;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_addr == PTR_W'(i)) begin
                w_rd_next = w_rd_bank[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data    <= RESET_GAIN;
            r_cfg_update <= 1'b0;
        end else begin
            r_rd_data    <= w_rd_next;
`ifdef EQ_SHADOW_COMMIT_EN
            r_cfg_update <= i_commit;
`else
            r_cfg_update <= i_wr_en;
`endif
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_cfg_update = r_cfg_update;

endmodule : eq_reg_bank
`default_nettype wire

// File: rtl/eq_i2c_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eq_i2c_reg_ctrl
// Description : Register-map controller between an I2C slave byte interface
//               and the equalizer gain datapath. A write transaction carries
//               a pointer byte followed by data bytes; a read transaction
//               streams register contents from the current pointer. The
//               pointer auto-increments and wraps at NUM_REGS-1; a pointer at
//               or beyond NUM_REGS stays put and flags err_oor.
// Ports       : clk, reset (async, active-low)
//               xfer_active, xfer_rw, rx_data, rx_valid, tx_req : slave side
//               tx_data     : next byte for the slave
//               gains_flat  : active gains, reg i at [8i+7:8i]
//               cfg_update  : 1-cycle pulse when gains_flat changes
//               ptr         : current register pointer
//               err_oor     : sticky out-of-range flag, cleared on new START
// Config      : EQ_SHADOW_COMMIT_EN - writes collect in a shadow bank and are
//               committed to the active bank at STOP.
// Revision    : 1.0 - initial release
// ============================================================================
module eq_i2c_reg_ctrl
    import eq_reg_pkg::*;
#(
    parameter int                NUM_REGS   = 10,
    parameter logic [GAIN_W-1:0] RESET_GAIN = DEF_RESET_GAIN,
    parameter logic [GAIN_W-1:0] OOR_DATA   = DEF_OOR_DATA
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       xfer_active,
    input  logic                       xfer_rw,
    input  logic [GAIN_W-1:0]          rx_data,
    input  logic                       rx_valid,
    input  logic                       tx_req,
    output logic [GAIN_W-1:0]          tx_data,
    output logic [NUM_REGS*GAIN_W-1:0] gains_flat,
    output logic                       cfg_update,
    output logic [PTR_W-1:0]           ptr,
    output logic                       err_oor
);

    localparam logic [PTR_W-1:0] c_num_regs = PTR_W'(NUM_REGS);
    localparam logic [PTR_W-1:0] c_last_reg = PTR_W'(NUM_REGS - 1);

    logic [STATE_W-1:0] r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_err;
    logic               r_xfer_prev;
    logic               r_dirty;     // in-range write seen in this transaction

    logic               w_rise;
    logic               w_fall;
    logic               w_in_range;
    logic [PTR_W-1:0]   w_ptr_adv;
    logic               w_wr_en;
    logic               w_commit;

    assign w_rise     = xfer_active & ~r_xfer_prev;
    assign w_fall     = ~xfer_active & r_xfer_prev;
    assign w_in_range = (r_ptr < c_num_regs);

    // Wrap from the last register to 0; an out-of-range pointer is frozen.
    assign w_ptr_adv  = (r_ptr == c_last_reg) ? '0 :
                        (w_in_range ? r_ptr + 8'd1 : r_ptr);

    assign w_wr_en    = (r_state == c_st_wr) && rx_valid && w_in_range;

    // A data byte arriving together with STOP still joins the commit.
    assign w_commit   = (r_state != c_st_idle) && w_fall && (r_dirty || w_wr_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_st_idle;
            r_ptr       <= '0;
            r_err       <= 1'b0;
            r_xfer_prev <= 1'b0;
            r_dirty     <= 1'b0;
        end else begin
            r_xfer_prev <= xfer_active;

            case (r_state)
                c_st_idle: begin
                    if (w_rise) begin
                        r_err   <= 1'b0;
                        r_dirty <= 1'b0;
                        r_state <= xfer_rw ? c_st_rd : c_st_ptr;
                    end
                end
                c_st_ptr: begin
                    if (rx_valid) begin
                        r_ptr   <= rx_data;
                        r_state <= c_st_wr;
                    end
                end
                c_st_wr: begin
                    if (rx_valid) begin
                        if (w_in_range) begin
                            r_dirty <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                        end
                        r_ptr <= w_ptr_adv;
                    end
                end
                c_st_rd: begin
                    if (tx_req) begin
                        if (!w_in_range) begin
                            r_err <= 1'b1;
                        end
                        r_ptr <= w_ptr_adv;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            // STOP ends any transaction; the byte handling above still applies.
            if ((r_state != c_st_idle) && w_fall) begin
                r_state <= c_st_idle;
                r_dirty <= 1'b0;
            end
        end
    end

    eq_reg_bank #(
        .NUM_REGS   (NUM_REGS),
        .RESET_GAIN (RESET_GAIN),
        .OOR_DATA   (OOR_DATA)
    ) u_bank (
        .clk          (clk),
        .reset        (reset),
        .i_wr_en      (w_wr_en),
        .i_wr_addr    (r_ptr),
        .i_wr_data    (rx_data),
        .i_commit     (w_commit),
        .i_rd_addr    (r_ptr),
        .o_rd_data    (tx_data),
        .o_gains_flat (gains_flat),
        .o_cfg_update (cfg_update)
    );

    assign ptr     = r_ptr;
    assign err_oor = r_err;

endmodule : eq_i2c_reg_ctrl
`default_nettype wire

// File: tb/tb_eq_i2c_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eq_i2c_reg_ctrl
// Description : Self-checking bench for eq_i2c_reg_ctrl. Directed scenarios
//               followed by random write/read transactions; a register-level
//               reference model predicts read bytes and gain updates, which a
//               monitor compares as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eq_i2c_reg_ctrl;

    localparam int N = 10;
    localparam int W = N * 8;
    localparam logic [7:0] c_reset_gain = 8'h80;
    localparam logic [7:0] c_oor        = 8'hFF;

    logic         clk = 1'b0;
    logic         reset;
    logic         xfer_active;
    logic         xfer_rw;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         tx_req;
    logic [7:0]   tx_data;
    logic [W-1:0] gains_flat;
    logic         cfg_update;
    logic [7:0]   ptr;
    logic         err_oor;

    eq_i2c_reg_ctrl #(
        .NUM_REGS   (N),
        .RESET_GAIN (8'h80),
        .OOR_DATA   (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .xfer_active (xfer_active),
        .xfer_rw     (xfer_rw),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .gains_flat  (gains_flat),
        .cfg_update  (cfg_update),
        .ptr         (ptr),
        .err_oor     (err_oor)
    );

    always #5 clk = ~clk;

    // Reference model: register contents as the master sees them
    logic [7:0]   m_active [N];
    logic [7:0]   m_shadow [N];
    logic [7:0]   m_ptr;
    logic         m_err;

    logic [W-1:0] cfg_q [$];   // expected gains at each cfg_update pulse
    logic [7:0]   rd_q  [$];   // expected byte at each tx_req
    logic [7:0]   xfer_bytes [$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [7:0] adv(input logic [7:0] p);
        if (int'(p) == N - 1) return 8'd0;
        if (int'(p) >= N)     return p;
        return p + 8'd1;
    endfunction

    function automatic logic [W-1:0] flat_active();
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) v[i*8 +: 8] = m_active[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_active[i] = c_reset_gain;
            m_shadow[i] = c_reset_gain;
        end
        m_ptr = 8'd0;
        m_err = 1'b0;
    endtask

    task automatic idle_checks(input string tag);
        logic [7:0] exp_tx;
        exp_tx = (int'(m_ptr) < N) ? m_shadow[m_ptr] : c_oor;
        check({tag, "_ptr"},   W'(ptr),     W'(m_ptr));
        check({tag, "_err"},   W'(err_oor), W'(m_err));
        check({tag, "_gains"}, gains_flat,  flat_active());
        check({tag, "_tx"},    W'(tx_data), W'(exp_tx));
    endtask

    // Write transaction carrying xfer_bytes (pointer first, then data)
    task automatic wr_xfer(input string tag);
        logic [W-1:0] old_flat;
        logic [W-1:0] mid_exp;
        bit           dirty;
        bit           same_cycle;
        int           nb;

        nb       = xfer_bytes.size();
        old_flat = flat_active();
        dirty    = 1'b0;
        m_err    = 1'b0;
        foreach (xfer_bytes[i]) begin
            if (i == 0) begin
                m_ptr = xfer_bytes[i];
            end else begin
                if (int'(m_ptr) < N) begin
                    m_shadow[m_ptr] = xfer_bytes[i];
                    dirty = 1'b1;
`ifndef EQ_SHADOW_COMMIT_EN
                    m_active[m_ptr] = xfer_bytes[i];
                    cfg_q.push_back(flat_active());
`endif
                end else begin
                    m_err = 1'b1;
                end
                m_ptr = adv(m_ptr);
            end
        end
`ifdef EQ_SHADOW_COMMIT_EN
        mid_exp = old_flat;
        if (dirty) begin
            m_active = m_shadow;
            cfg_q.push_back(flat_active());
        end
`else
        mid_exp = flat_active();
`endif

        xfer_rw     = 1'b0;
        xfer_active = 1'b1;
        tick();
        tick();
        same_cycle = 1'($urandom_range(0, 1));
        for (int i = 0; i < nb; i++) begin
            rx_data  = xfer_bytes[i];
            rx_valid = 1'b1;
            if (i == nb - 1 && same_cycle) xfer_active = 1'b0;
            tick();
            rx_valid = 1'b0;
            if (i != nb - 1) repeat ($urandom_range(0, 2)) tick();
        end
        if (!same_cycle) begin
            tick();
            check({tag, "_gains_before_stop"}, gains_flat, mid_exp);
            xfer_active = 1'b0;
        end
        repeat (3) tick();
        idle_checks(tag);
    endtask

    task automatic rd_xfer(input string tag, input int n);
        m_err = 1'b0;
        for (int k = 0; k < n; k++) begin
            rd_q.push_back((int'(m_ptr) < N) ? m_shadow[m_ptr] : c_oor);
            if (int'(m_ptr) >= N) m_err = 1'b1;
            m_ptr = adv(m_ptr);
        end
        xfer_rw     = 1'b1;
        xfer_active = 1'b1;
        tick();
        tick();
        check({tag, "_err_cleared"}, W'(err_oor), W'(1'b0));
        for (int k = 0; k < n; k++) begin
            tx_req = 1'b1;
            tick();
            tx_req = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
        end
        xfer_active = 1'b0;
        repeat (3) tick();
        idle_checks(tag);
    endtask

    // Monitor: compares every presented byte / gain update against the queues
    always @(negedge clk) begin
        if (reset) begin
            if (cfg_update) begin
                if (cfg_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL cfg_update_unexpected: got pulse expected none at %0t", $time);
                end else begin
                    check("cfg_update_gains", gains_flat, cfg_q.pop_front());
                end
            end
            if (tx_req) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got tx_req with no expected byte at %0t", $time);
                end else begin
                    check("tx_data", W'(tx_data), W'(rd_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        xfer_active = 1'b0;
        xfer_rw     = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        tx_req      = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();

        // Reset state
        idle_checks("reset");
        check("reset_cfg_update", W'(cfg_update), W'(1'b0));

        // Two data bytes from pointer 3
        xfer_bytes = '{8'd3, 8'h11, 8'h22};
        wr_xfer("wr3");

        // Wrap from the last register to 0
        xfer_bytes = '{8'd9, 8'hAA, 8'hBB};
        wr_xfer("wrap");

        // Pointer-only write followed by a read of three bytes
        xfer_bytes = '{8'd2};
        wr_xfer("setptr");
        rd_xfer("rd3", 3);

        // Out-of-range pointer: no change, error flag, OOR read data
        xfer_bytes = '{8'd12, 8'h55};
        wr_xfer("oor_wr");
        rd_xfer("oor_rd", 1);

        // Reset in the middle of a write after a data byte
        xfer_bytes = '{8'd5, 8'h3C};
        m_err = 1'b0;
        m_shadow[5] = 8'h3C;
`ifndef EQ_SHADOW_COMMIT_EN
        m_active[5] = 8'h3C;
        cfg_q.push_back(flat_active());
`endif
        xfer_rw     = 1'b0;
        xfer_active = 1'b1;
        tick();
        tick();
        rx_data  = 8'd5;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #3;
        xfer_active = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
        repeat (2) tick();
        idle_checks("midreset");

        // Controller is back in IDLE and accepts a fresh transaction
        xfer_bytes = '{8'd0, 8'h01};
        wr_xfer("after_reset");

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 2) != 2) begin
                int nd;
                xfer_bytes.delete();
                xfer_bytes.push_back(8'($urandom_range(0, 13)));
                nd = $urandom_range(0, 4);
                for (int k = 0; k < nd; k++) xfer_bytes.push_back(8'($urandom));
                wr_xfer("rand_wr");
            end else begin
                rd_xfer("rand_rd", $urandom_range(1, 4));
            end
        end

        repeat (4) tick();
        check("cfg_q_drained", W'(cfg_q.size()), W'(0));
        check("rd_q_drained",  W'(rd_q.size()),  W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_eq_i2c_reg_ctrl
`default_nettype wire
